// File: rtl/store_rmw_pkg.sv
// Shared types and helpers for the store read-modify-write sequencer.
package store_rmw_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Byte lanes touched by a store of the given size starting at lane.
  function automatic logic [7:0] byte_mask(input size_e sz, input logic [2:0] lane);
    logic [7:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [2:0] low);
    logic mis;
    case (sz)
      SZ_H:    mis = low[0];
      SZ_W:    mis = |low[1:0];
      SZ_D:    mis = |low;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge of right-aligned store data into a read doubleword.
// Zero latency; no flow control.
module store_lane_merge
  import store_rmw_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [63:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [2:0]  lane_i,
  output logic [63:0] merged_o
);

  logic [7:0]  mask;
  logic [63:0] shifted;

  always_comb begin
    mask     = byte_mask(size_e'(size_i), lane_i);
    shifted  = data_i << {lane_i, 3'b000};
    merged_o = rdata_i;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) merged_o[8*k +: 8] = shifted[8*k +: 8];
    end
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Read-merge-write sequencer for sub-word stores; done lands RD_LAT+3 cycles after accept.
// Owns the memory port while busy, ignores req until back in IDLE. Option: STORE_RMW_FULL_SKIP_EN.
module store_rmw_ctrl
  import store_rmw_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [63:0] addr,
  input  logic [1:0]  size,
  input  logic [63:0] data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] data_q, data_d;
  logic [63:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] merged;

  store_lane_merge u_merge (
    .rdata_i  (mem_rdata),
    .data_i   (data_q),
    .size_i   (size_q),
    .lane_i   (addr_q[2:0]),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = addr;
          size_d = size;
          data_d = data;
          err_d  = 1'b0;
          if (misaligned(size_e'(size), addr[2:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
`ifdef STORE_RMW_FULL_SKIP_EN
          // A full doubleword overwrites every lane, so the read is pointless.
          else if (size_e'(size) == SZ_D) begin
            wdata_d = data;
            state_d = ST_WRITE;
          end
`endif
          else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          wdata_d = merged;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign mem_rd    = (state_q == ST_READ);
  assign mem_wr    = (state_q == ST_WRITE);
  assign mem_addr  = {addr_q[63:3], 3'b000};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (RD_LAT 1 and 3) against a byte-level memory model.
module tb_store_rmw_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_v[2];
  logic [63:0] addr_v[2];
  logic [1:0]  size_v[2];
  logic [63:0] data_v[2];
  logic        busy_v[2], done_v[2], err_v[2], mem_rd_v[2], mem_wr_v[2];
  logic [63:0] mem_addr_v[2], mem_wdata_v[2], mem_rdata_v[2];

  store_rmw_ctrl #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .addr(addr_v[0]), .size(size_v[0]),
    .data(data_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .mem_rd(mem_rd_v[0]), .mem_wr(mem_wr_v[0]), .mem_addr(mem_addr_v[0]),
    .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0])
  );

  store_rmw_ctrl #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .addr(addr_v[1]), .size(size_v[1]),
    .data(data_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .mem_rd(mem_rd_v[1]), .mem_wr(mem_wr_v[1]), .mem_addr(mem_addr_v[1]),
    .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1])
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_bad = 0;
  logic [63:0] mem[2][16];
  int rd_at[2];
  bit rd_pend[2];

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: valid data only exactly RD_LAT cycles after mem_rd, noise otherwise.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) rd_pend[g] = 1'b0;
      else if (mem_rd_v[g]) begin
        rd_pend[g] = 1'b1;
        rd_at[g]   = cyc;
      end
      if (rd_pend[g] && cyc == rd_at[g] + lat(g)) begin
        mem_rdata_v[g] = mem[g][mem_addr_v[g][6:3]];
        rd_pend[g]     = 1'b0;
      end else begin
        mem_rdata_v[g] = {$urandom, $urandom};
      end
      if (err_v[g] && !done_v[g]) err_bad++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_merge(input logic [63:0] old, input logic [63:0] a,
                                              input logic [1:0] sz, input logic [63:0] d);
    logic [63:0] r;
    int n, lane;
    r = old;
    n = 1 << sz;
    lane = int'(a % 8);
    for (int k = 0; k < n; k++) r[8*(lane+k) +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic bit model_mis(input logic [63:0] a, input logic [1:0] sz);
    return (a % (64'd1 << sz)) != 0;
  endfunction

  task automatic do_store(input int g, input logic [63:0] a, input logic [1:0] sz,
                          input logic [63:0] d, output int rd_c, output int wr_c,
                          output int dn_c, output int n_rd, output int n_wr,
                          output logic e, output logic [63:0] wd, output logic [63:0] wa,
                          output int busy_bad);
    int c0;
    @(negedge clk);
    req_v[g] = 1'b1; addr_v[g] = a; size_v[g] = sz; data_v[g] = d;
    c0 = cyc; rd_c = -1; wr_c = -1; dn_c = -1; n_rd = 0; n_wr = 0;
    e = 1'b0; wd = '0; wa = '0; busy_bad = 0;
    for (int t = 1; t <= 40 && dn_c < 0; t++) begin
      @(negedge clk);
      if (!busy_v[g]) busy_bad++;
      if (mem_rd_v[g]) begin
        n_rd++;
        if (rd_c < 0) rd_c = cyc - c0;
      end
      if (mem_wr_v[g]) begin
        n_wr++; wr_c = cyc - c0; wd = mem_wdata_v[g]; wa = mem_addr_v[g];
      end
      if (done_v[g]) begin
        dn_c = cyc - c0; e = err_v[g]; req_v[g] = 1'b0;
      end else begin
        // Requester keeps req up but the other inputs are free to wander.
        addr_v[g] = {$urandom, $urandom}; data_v[g] = {$urandom, $urandom};
        size_v[g] = 2'($urandom);
      end
    end
    req_v[g] = 1'b0;
    if (dn_c >= 0) begin
      @(negedge clk);
      if (busy_v[g]) busy_bad++;
    end
  endtask

  task automatic check_store(input string nm, input int g, input logic [63:0] a,
                             input logic [1:0] sz, input logic [63:0] d,
                             output logic [63:0] wd_out, output logic e_out);
    int rd_c, wr_c, dn_c, n_rd, n_wr, bb;
    int e_rd, e_wr, e_dn;
    logic e;
    logic [63:0] wd, wa, exp_wd;
    bit mis;
    mis = model_mis(a, sz);
    exp_wd = model_merge(mem[g][a[6:3]], a, sz, d);
    if (mis) begin
      e_rd = -1; e_wr = -1; e_dn = 1;
    end else begin
      e_rd = 1; e_wr = 2 + lat(g); e_dn = 3 + lat(g);
`ifdef STORE_RMW_FULL_SKIP_EN
      if (sz == 2'b11) begin
        e_rd = -1; e_wr = 1; e_dn = 2;
      end
`endif
    end
    do_store(g, a, sz, d, rd_c, wr_c, dn_c, n_rd, n_wr, e, wd, wa, bb);
    chk({nm, " done_cycle"}, 64'(dn_c), 64'(e_dn));
    chk({nm, " err"}, {63'd0, e}, {63'd0, mis});
    chk({nm, " rd_cycle"}, 64'(rd_c), 64'(e_rd));
    chk({nm, " wr_cycle"}, 64'(wr_c), 64'(e_wr));
    chk({nm, " n_rd"}, 64'(n_rd), (e_rd < 0) ? 64'd0 : 64'd1);
    chk({nm, " n_wr"}, 64'(n_wr), mis ? 64'd0 : 64'd1);
    chk({nm, " busy"}, 64'(bb), 64'd0);
    if (!mis) begin
      chk({nm, " wdata"}, wd, exp_wd);
      chk({nm, " waddr"}, wa, {a[63:3], 3'b000});
      mem[g][a[6:3]] = exp_wd;
    end
    wd_out = wd;
    e_out  = e;
  endtask

  typedef struct {
    int          g;
    logic [63:0] init;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] exp_wd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [63:0] wd;
    logic        e;
    int          c0, nr, nd, quiet;
    int          rdc[2], dnc[2];
    logic [63:0] wdh;

    for (int g = 0; g < 2; g++) begin
      req_v[g] = 0; addr_v[g] = 0; size_v[g] = 0; data_v[g] = 0;
      for (int i = 0; i < 16; i++) mem[g][i] = {$urandom, $urandom};
    end

    vecs[0]  = '{0, 64'h1122334455667788, 64'h103, 2'b00, 64'hAA, 64'h11223344AA667788, 1'b0};
    vecs[1]  = '{0, 64'h1122334455667788, 64'h106, 2'b01, 64'hBEEF, 64'hBEEF334455667788, 1'b0};
    vecs[2]  = '{0, 64'h1122334455667788, 64'h104, 2'b10, 64'hDEADBEEF, 64'hDEADBEEF55667788, 1'b0};
    vecs[3]  = '{0, 64'h1122334455667788, 64'h101, 2'b01, 64'h1234, 64'h0, 1'b1};
    vecs[4]  = '{1, 64'h1122334455667788, 64'h100, 2'b00, 64'h00, 64'h1122334455667700, 1'b0};
    vecs[5]  = '{0, 64'h1122334455667788, 64'h100, 2'b11, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0};
    vecs[6]  = '{1, 64'h1122334455667788, 64'h100, 2'b11, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0};
    vecs[7]  = '{0, 64'h1122334455667788, 64'h102, 2'b10, 64'h0, 64'h0, 1'b1};
    vecs[8]  = '{0, 64'h1122334455667788, 64'h104, 2'b11, 64'h0, 64'h0, 1'b1};
    vecs[9]  = '{1, 64'h1122334455667788, 64'h10E, 2'b01, 64'hFFFF_0000_0000_1234, 64'h1234334455667788, 1'b0};
    vecs[10] = '{0, 64'h1122334455667788, 64'h107, 2'b00, 64'hFFFF_FF5A, 64'h5A22334455667788, 1'b0};
    vecs[11] = '{1, 64'h1122334455667788, 64'h101, 2'b11, 64'h0, 64'h0, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst%0d busy", g), {63'd0, busy_v[g]}, 64'd0);
      chk($sformatf("rst%0d done", g), {63'd0, done_v[g]}, 64'd0);
      chk($sformatf("rst%0d err", g), {63'd0, err_v[g]}, 64'd0);
      chk($sformatf("rst%0d rdwr", g), {62'd0, mem_rd_v[g], mem_wr_v[g]}, 64'd0);
      chk($sformatf("rst%0d addr", g), mem_addr_v[g], 64'd0);
      chk($sformatf("rst%0d wdata", g), mem_wdata_v[g], 64'd0);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      mem[vecs[i].g][vecs[i].addr[6:3]] = vecs[i].init;
      check_store($sformatf("vec%0d", i), vecs[i].g, vecs[i].addr, vecs[i].size,
                  vecs[i].data, wd, e);
      chk($sformatf("vec%0d tab_err", i), {63'd0, e}, {63'd0, vecs[i].exp_err});
      if (!vecs[i].exp_err) chk($sformatf("vec%0d tab_wdata", i), wd, vecs[i].exp_wd);
    end

    // Reset pulled during WAIT on the RD_LAT=3 instance.
    mem[1][0] = 64'h1122334455667788;
    @(negedge clk);
    req_v[1] = 1'b1; addr_v[1] = 64'h100; size_v[1] = 2'b00; data_v[1] = 64'h55;
    repeat (2) @(negedge clk);
    chk("mid busy_before", {63'd0, busy_v[1]}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid busy", {63'd0, busy_v[1]}, 64'd0);
    chk("mid outs", {61'd0, done_v[1], mem_rd_v[1], mem_wr_v[1]}, 64'd0);
    chk("mid wdata", mem_wdata_v[1], 64'd0);
    req_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_wr_v[1] || done_v[1] || busy_v[1]) quiet++;
    end
    chk("mid no_followup", 64'(quiet), 64'd0);
    check_store("post_rst", 1, 64'h100, 2'b00, 64'h5A, wd, e);

    // Held req: second store accepted in the IDLE cycle right after done.
    mem[0][2] = 64'hCAFEF00D12345678;
    @(negedge clk);
    req_v[0] = 1'b1; addr_v[0] = 64'h110; size_v[0] = 2'b00; data_v[0] = 64'h77;
    c0 = cyc; nr = 0; nd = 0; wdh = '0;
    rdc = '{-1, -1}; dnc = '{-1, -1};
    for (int t = 1; t <= 30 && nd < 2; t++) begin
      @(negedge clk);
      if (mem_rd_v[0]) begin
        if (nr < 2) rdc[nr] = cyc - c0;
        nr++;
      end
      if (mem_wr_v[0]) wdh = mem_wdata_v[0];
      if (done_v[0]) begin
        if (nd < 2) dnc[nd] = cyc - c0;
        nd++;
      end
    end
    req_v[0] = 1'b0;
    chk("held n_rd", 64'(nr), 64'd2);
    chk("held rd0", 64'(rdc[0]), 64'd1);
    chk("held done0", 64'(dnc[0]), 64'd4);
    chk("held rd1", 64'(rdc[1]), 64'd6);
    chk("held done1", 64'(dnc[1]), 64'd9);
    chk("held wdata", wdh, 64'hCAFEF00D12345677);
    mem[0][2] = 64'hCAFEF00D12345677;
    @(negedge clk);

    // Randomized stores on both instances.
    for (int i = 0; i < 200; i++) begin
      int g;
      g = int'($urandom_range(0, 1));
      check_store($sformatf("rnd%0d", i), g, {$urandom, $urandom}, 2'($urandom),
                  {$urandom, $urandom}, wd, e);
    end

    chk("err_only_with_done", 64'(err_bad), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
